// File: rtl/run_controller.sv
// run_controller: run/stop/step sequencer producing the CPU commit enable
module run_controller #(
    parameter int CNT_W     = 16,
    parameter int MAX_INSTR = 0
) (
    input  logic             clk_1s,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       pc,
    input  logic [7:0]       instr,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic [1:0]       halt_cause,
    output logic             bp_flag
);
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, PAUSE = 3'd3, HALT = 3'd4} state_t;
    state_t cur, nxt;
    logic bp_skip, skip_n, flag_n;
    logic [1:0] cause_n;
    // a branch with offset -1 targets itself, so the program can never leave it
    wire self_loop = (instr[7:6] == 2'b11) && (instr[1:0] == 2'b11);
    // bp_skip lets the instruction sitting at the breakpoint retire once after resuming
    wire bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
    wire lim = (MAX_INSTR != 0) && (instr_count == CNT_W'(MAX_INSTR));
    assign state = cur;
    // next state, commit enable and status updates; clear wins over everything
    always_comb begin
        nxt = cur;
        cpu_en = 1'b0;
        cause_n = halt_cause;
        flag_n = bp_flag;
        skip_n = bp_skip;
        if (clear) nxt = IDLE;
        else begin
            case (cur)
                IDLE: nxt = stop ? IDLE : step ? STEP : start ? RUN : IDLE;
                RUN: begin
                    if (stop) nxt = PAUSE;
                    else if (self_loop) begin
                        nxt = HALT;
                        cause_n = 2'b01;
                    end else if (lim) begin
                        nxt = HALT;
                        cause_n = 2'b10;
                    end else if (bp_hit) begin
                        nxt = PAUSE;
                        flag_n = 1'b1;
                    end else cpu_en = 1'b1;
                end
                STEP: begin
                    if (self_loop) begin
                        nxt = HALT;
                        cause_n = 2'b01;
                    end else if (lim) begin
                        nxt = HALT;
                        cause_n = 2'b10;
                    end else begin
                        cpu_en = 1'b1;
                        nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (!stop && (step || start)) begin
                        nxt = step ? STEP : RUN;
                        skip_n = 1'b1;
                        flag_n = 1'b0;
                    end
                end
                default: nxt = cur;
            endcase
        end
        if (cpu_en) skip_n = 1'b0;
        if (nxt == IDLE) begin
            cause_n = 2'b00;
            flag_n = 1'b0;
        end
    end
    // state and status registers with asynchronous reset
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            cur <= IDLE;
            halt_cause <= 2'b00;
            bp_flag <= 1'b0;
            bp_skip <= 1'b0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            halt_cause <= cause_n;
            bp_flag <= flag_n;
            bp_skip <= skip_n;
            instr_count <= clear ? '0 : (cpu_en && !(&instr_count)) ? instr_count + CNT_W'(1) : instr_count;
        end
    end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed bench with a behavioural model for three controller variants
module tb_run_controller;
    logic clk_1s = 1'b0, reset, start, stop, step, clear, bp_en;
    logic [7:0] bp_addr, pc, instr;
    logic d_en [3];
    logic [2:0] d_st [3];
    logic [1:0] d_cause [3];
    logic d_flag [3];
    logic [15:0] d_cnt [2];
    logic [2:0] cnt_s;
    int ntests = 0, nfail = 0;
    localparam int IDLE = 0, RUN = 1, STEP = 2, PAUSE = 3, HALT = 4;
    int lims [3] = '{0, 10, 0};
    int maxc [3] = '{65535, 65535, 7};
    int ms [3], mc [3], mcause [3], mflag [3], mskip [3];

    always #5 clk_1s = ~clk_1s;

    run_controller dut0 (.clk_1s(clk_1s), .reset(reset), .start(start), .stop(stop), .step(step), .clear(clear),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr), .cpu_en(d_en[0]), .state(d_st[0]),
        .instr_count(d_cnt[0]), .halt_cause(d_cause[0]), .bp_flag(d_flag[0]));
    run_controller #(.MAX_INSTR(10)) dut1 (.clk_1s(clk_1s), .reset(reset), .start(start), .stop(stop), .step(step),
        .clear(clear), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr), .cpu_en(d_en[1]), .state(d_st[1]),
        .instr_count(d_cnt[1]), .halt_cause(d_cause[1]), .bp_flag(d_flag[1]));
    run_controller #(.CNT_W(3)) dut2 (.clk_1s(clk_1s), .reset(reset), .start(start), .stop(stop), .step(step),
        .clear(clear), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr), .cpu_en(d_en[2]), .state(d_st[2]),
        .instr_count(cnt_s), .halt_cause(d_cause[2]), .bp_flag(d_flag[2]));

    task automatic chk(string name, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_sl();
        return instr[7:6] == 2'b11 && instr[1:0] == 2'b11;
    endfunction
    function automatic bit m_lim(int i);
        return lims[i] != 0 && mc[i] == lims[i];
    endfunction
    function automatic bit m_bp(int i);
        return bp_en && pc == bp_addr && mskip[i] == 0;
    endfunction
    function automatic bit m_en(int i);
        if (clear || m_sl() || m_lim(i)) return 1'b0;
        if (ms[i] == RUN) return !stop && !m_bp(i);
        return ms[i] == STEP;
    endfunction

    // behavioural model: what each controller variant must do on every edge
    always @(posedge clk_1s or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                ms[i] = IDLE; mc[i] = 0; mcause[i] = 0; mflag[i] = 0; mskip[i] = 0;
            end else begin
                bit e;
                int nx;
                e = m_en(i);
                nx = ms[i];
                if (clear) nx = IDLE;
                else if (ms[i] == IDLE) nx = stop ? IDLE : step ? STEP : start ? RUN : IDLE;
                else if (ms[i] == RUN && stop) nx = PAUSE;
                else if ((ms[i] == RUN || ms[i] == STEP) && m_sl()) begin nx = HALT; mcause[i] = 1; end
                else if ((ms[i] == RUN || ms[i] == STEP) && m_lim(i)) begin nx = HALT; mcause[i] = 2; end
                else if (ms[i] == RUN && m_bp(i)) begin nx = PAUSE; mflag[i] = 1; end
                else if (ms[i] == STEP) nx = PAUSE;
                else if (ms[i] == PAUSE && !stop && (step || start)) begin
                    nx = step ? STEP : RUN; mskip[i] = 1; mflag[i] = 0;
                end
                if (e) mskip[i] = 0;
                if (nx == IDLE) begin mcause[i] = 0; mflag[i] = 0; end
                if (clear) mc[i] = 0;
                else if (e && mc[i] < maxc[i]) mc[i]++;
                ms[i] = nx;
            end
        end
    end

    // compare every variant against the model on the falling edge
    always @(negedge clk_1s) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cpu_en[%0d]", i), int'(d_en[i]), int'(m_en(i)));
                chk($sformatf("state[%0d]", i), int'(d_st[i]), ms[i]);
                chk($sformatf("count[%0d]", i), i == 2 ? int'(cnt_s) : int'(d_cnt[i]), mc[i]);
                chk($sformatf("halt_cause[%0d]", i), int'(d_cause[i]), mcause[i]);
                chk($sformatf("bp_flag[%0d]", i), int'(d_flag[i]), mflag[i]);
            end
        end
    end

    task automatic tick(int n = 1);
        for (int k = 0; k < n; k++) begin
            bit a;
            a = m_en(0);
            @(posedge clk_1s);
            #1;
            if (a) pc = pc + 8'd1;
        end
    endtask

    initial begin
        reset = 1'b0; start = 0; stop = 0; step = 0; clear = 0; bp_en = 0; bp_addr = 8'h00; pc = 8'h00; instr = 8'h15;
        #1 reset = 1'b1;
        #1;
        chk("reset_state", int'(d_st[0]), 0);
        chk("reset_cpu_en", int'(d_en[0]), 0);
        chk("reset_count", int'(d_cnt[0]), 0);
        chk("reset_cause", int'(d_cause[0]), 0);
        @(negedge clk_1s);
        reset = 1'b0;
        // run from pc 0, stop at pc 4
        start = 1; tick(); start = 0;
        tick(4);
        stop = 1; tick(); stop = 0; #1;
        chk("t1_state", int'(d_st[0]), 3);
        chk("t1_count", int'(d_cnt[0]), 4);
        chk("t1_pc", int'(pc), 4);
        chk("t1_cpu_en", int'(d_en[0]), 0);
        // breakpoint at 3, resume retires pc 3 once, retrigger on return
        clear = 1; tick(); clear = 0;
        pc = 0; bp_en = 1; bp_addr = 8'h03;
        start = 1; tick(); start = 0;
        tick(3); #1;
        chk("t2_bp_cpu_en", int'(d_en[0]), 0);
        tick();
        chk("t2_state", int'(d_st[0]), 3);
        chk("t2_flag", int'(d_flag[0]), 1);
        chk("t2_count", int'(d_cnt[0]), 3);
        chk("t2_pc", int'(pc), 3);
        start = 1; tick(); start = 0;
        tick();
        chk("t2_resume_count", int'(d_cnt[0]), 4);
        chk("t2_resume_state", int'(d_st[0]), 1);
        chk("t2_resume_flag", int'(d_flag[0]), 0);
        pc = 8'h03;
        tick();
        chk("t2_retrig_state", int'(d_st[0]), 3);
        chk("t2_retrig_flag", int'(d_flag[0]), 1);
        // three single steps from PAUSE, last with breakpoint on current pc
        for (int s = 0; s < 3; s++) begin
            if (s == 2) bp_addr = pc;
            step = 1; tick(); step = 0; #1;
            chk("t3_step_state", int'(d_st[0]), 2);
            chk("t3_step_en", int'(d_en[0]), 1);
            tick();
            chk("t3_pause_state", int'(d_st[0]), 3);
            chk("t3_count", int'(d_cnt[0]), 5 + s);
        end
        // self-loop halt at pc 5
        clear = 1; tick(); clear = 0;
        bp_en = 0; pc = 0;
        start = 1; tick(); start = 0;
        tick(5);
        instr = 8'hC3; #1;
        chk("t4_loop_en", int'(d_en[0]), 0);
        chk("t4_pc", int'(pc), 5);
        tick();
        chk("t4_halt_state", int'(d_st[0]), 4);
        chk("t4_halt_cause", int'(d_cause[0]), 1);
        start = 1; tick(); start = 0;
        step = 1; tick(); step = 0;
        chk("t4_still_halt", int'(d_st[0]), 4);
        clear = 1; tick(); clear = 0;
        chk("t4_clr_state", int'(d_st[0]), 0);
        chk("t4_clr_count", int'(d_cnt[0]), 0);
        chk("t4_clr_cause", int'(d_cause[0]), 0);
        instr = 8'h15;
        // free run: limit variant halts at 10, narrow counter saturates at 7
        start = 1; tick(); start = 0;
        tick(12);
        chk("t5_lim_state", int'(d_st[1]), 4);
        chk("t5_lim_cause", int'(d_cause[1]), 2);
        chk("t5_lim_count", int'(d_cnt[1]), 10);
        chk("t5_lim_en", int'(d_en[1]), 0);
        chk("t5_sat_count", int'(cnt_s), 7);
        chk("t5_run_count", int'(d_cnt[0]), 12);
        chk("t5_run_state", int'(d_st[0]), 1);
        // asynchronous reset in the middle of a run cycle
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_en", int'(d_en[0]), 0);
        chk("t6_rst_state", int'(d_st[0]), 0);
        chk("t6_rst_count", int'(d_cnt[0]), 0);
        #1 reset = 1'b0; pc = 0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
